// File: rtl/i2c_frame_engine.sv
// -----------------------------------------------------------------------------
// i2c_frame_engine
//
// Emits one 9-clock I2C byte frame per request, in either direction, with an
// optional leading START (or repeated START when the bus is already held) and
// an optional trailing STOP. Each slot (START, one data bit, ACK, STOP) is four
// quarters of QUARTER clk_1MHz cycles.
//
// Build option:
//   I2C_NACK_AUTOSTOP_EN - when defined, a write frame whose ACK slot reads 1
//                          is always closed with a STOP, releasing the bus.
//
// Ports:
//   clk_1MHz    system clock
//   rst         asynchronous reset, active-high
//   en          frame request level, sampled only while idle
//   start_frame prepend START / repeated START
//   stop_frame  append STOP after the ACK slot
//   rw          0 = write frame, 1 = read frame
//   rd_nack     read frames: level driven in the ACK slot (1 = NACK)
//   data_in     write byte, sent MSB first
//   data_out    read byte, valid while done = 1
//   sda         open-drain style data line (driven only when sda_en = 1)
//   scl         serial clock
//   sda_en      1 = engine drives SDA, 0 = SDA released
//   busy        frame in progress
//   done        frame complete, held until en drops
//   nack        write frames: slave answered NACK (valid with done)
// -----------------------------------------------------------------------------
module i2c_frame_engine #(
    parameter int QUARTER = 2,
    parameter int QCNT_W  = $clog2(QUARTER) + 1
) (
    input  logic       clk_1MHz,
    input  logic       rst,
    input  logic       en,
    input  logic       start_frame,
    input  logic       stop_frame,
    input  logic       rw,
    input  logic       rd_nack,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    inout  wire        sda,
    output logic       scl,
    output logic       sda_en,
    output logic       busy,
    output logic       done,
    output logic       nack
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BITS  = 3'd2,
        ST_ACK   = 3'd3,
        ST_STOP  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t            state_r;
    logic [QCNT_W-1:0] qcnt_r;
    logic [1:0]        qtr_r;
    logic [2:0]        bit_r;
    logic              stop_r;
    logic              rw_r;
    logic              rd_nack_r;
    logic [7:0]        wdata_r;
    logic [7:0]        shift_r;
    logic              bus_held_r;
    logic              sda_out_r;

    logic              q_end_s;
    logic              slot_end_s;
    logic              sample_s;
    logic              scl_high_s;
    logic              autostop_s;

    assign q_end_s    = (qcnt_r == QCNT_W'(QUARTER - 1));
    assign slot_end_s = q_end_s && (qtr_r == 2'd3);
    assign scl_high_s = (qtr_r == 2'd1) || (qtr_r == 2'd2);

    // Pad outputs are registered from the current phase, so the pins trail the
    // phase counters by one cycle. The last cycle of q1 as seen on the pins is
    // therefore the cycle in which the counters sit on the first cycle of q2.
    assign sample_s   = (qtr_r == 2'd2) && (qcnt_r == {QCNT_W{1'b0}});

`ifdef I2C_NACK_AUTOSTOP_EN
    assign autostop_s = !rw_r && nack;
`else
    assign autostop_s = 1'b0;
`endif

    assign sda = sda_en ? sda_out_r : 1'bz;

    // Frame sequencer: quarter/bit counters, latched request, bus ownership and all pad/status outputs.
    always_ff @(posedge clk_1MHz or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            qcnt_r     <= {QCNT_W{1'b0}};
            qtr_r      <= 2'd0;
            bit_r      <= 3'd7;
            stop_r     <= 1'b0;
            rw_r       <= 1'b0;
            rd_nack_r  <= 1'b0;
            wdata_r    <= 8'h00;
            shift_r    <= 8'h00;
            bus_held_r <= 1'b0;
            sda_out_r  <= 1'b1;
            scl        <= 1'b1;
            sda_en     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            nack       <= 1'b0;
            data_out   <= 8'h00;
        end else begin
            if (state_r == ST_START || state_r == ST_BITS ||
                state_r == ST_ACK   || state_r == ST_STOP) begin
                if (q_end_s) begin
                    qcnt_r <= {QCNT_W{1'b0}};
                    qtr_r  <= qtr_r + 2'd1;
                end else begin
                    qcnt_r <= qcnt_r + QCNT_W'(1);
                end
            end

            case (state_r)
                ST_IDLE: begin
                    if (en) begin
                        stop_r    <= stop_frame;
                        rw_r      <= rw;
                        rd_nack_r <= rd_nack;
                        wdata_r   <= data_in;
                        busy      <= 1'b1;
                        nack      <= 1'b0;
                        qcnt_r    <= {QCNT_W{1'b0}};
                        qtr_r     <= 2'd0;
                        bit_r     <= 3'd7;
                        state_r   <= start_frame ? ST_START : ST_BITS;
                    end
                end

                ST_START: begin
                    sda_en <= 1'b1;
                    case (qtr_r)
                        // SCL is already at the idle level implied by bus ownership.
                        2'd0: begin sda_out_r <= 1'b1; scl <= !bus_held_r; end
                        2'd1: begin sda_out_r <= 1'b1; scl <= 1'b1; end
                        2'd2: begin sda_out_r <= 1'b0; scl <= 1'b1; end
                        2'd3: begin sda_out_r <= 1'b0; scl <= 1'b0; end
                        default: begin sda_out_r <= 1'b1; scl <= 1'b1; end
                    endcase
                    if (slot_end_s) begin
                        state_r <= ST_BITS;
                    end
                end

                ST_BITS: begin
                    sda_en    <= !rw_r;
                    sda_out_r <= wdata_r[bit_r];
                    scl       <= scl_high_s;
                    if (sample_s && rw_r) begin
                        shift_r <= {shift_r[6:0], sda};
                    end
                    if (slot_end_s) begin
                        if (bit_r == 3'd0) begin
                            state_r <= ST_ACK;
                        end else begin
                            bit_r <= bit_r - 3'd1;
                        end
                    end
                end

                ST_ACK: begin
                    sda_en    <= rw_r;
                    sda_out_r <= rd_nack_r;
                    scl       <= scl_high_s;
                    if (sample_s && !rw_r) begin
                        nack <= sda;
                    end
                    if (slot_end_s) begin
                        if (stop_r || autostop_s) begin
                            state_r <= ST_STOP;
                        end else begin
                            state_r    <= ST_DONE;
                            bus_held_r <= 1'b1;
                        end
                    end
                end

                ST_STOP: begin
                    scl       <= (qtr_r != 2'd0);
                    sda_out_r <= (qtr_r == 2'd2) || (qtr_r == 2'd3);
                    sda_en    <= (qtr_r != 2'd3);
                    if (slot_end_s) begin
                        state_r    <= ST_DONE;
                        bus_held_r <= 1'b0;
                    end
                end

                ST_DONE: begin
                    sda_en <= 1'b0;
                    busy   <= 1'b0;
                    if (rw_r) begin
                        data_out <= shift_r;
                    end
                    if (en) begin
                        done <= 1'b1;
                    end else begin
                        done    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end

                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_frame_engine.sv
// -----------------------------------------------------------------------------
// tb_i2c_frame_engine
//
// Randomised frame-level bench. For each frame the reference model lists the
// SDA levels expected at every SCL rising edge (who drives each one, and the
// value), whether a STOP follows, the START/STOP condition counts and the
// request-to-done latency. A bus monitor records what actually appears on the
// pins and a small slave answers read bits and write ACKs from the same list.
// -----------------------------------------------------------------------------
module tb_i2c_frame_engine;

    localparam int Q = 2;
`ifdef I2C_NACK_AUTOSTOP_EN
    localparam bit AUTOSTOP = 1'b1;
`else
    localparam bit AUTOSTOP = 1'b0;
`endif

    logic       clk_1MHz = 1'b0;
    logic       rst      = 1'b1;
    logic       en;
    logic       start_frame;
    logic       stop_frame;
    logic       rw;
    logic       rd_nack;
    logic [7:0] data_in;
    logic [7:0] data_out;
    wire        sda;
    logic       scl;
    logic       sda_en;
    logic       busy;
    logic       done;
    logic       nack;

    logic       slave_oe  = 1'b0;
    logic       slave_bit = 1'b1;

    assign sda = slave_oe ? slave_bit : 1'bz;
    pullup (sda);

    i2c_frame_engine #(.QUARTER(Q)) dut (
        .clk_1MHz    (clk_1MHz),
        .rst         (rst),
        .en          (en),
        .start_frame (start_frame),
        .stop_frame  (stop_frame),
        .rw          (rw),
        .rd_nack     (rd_nack),
        .data_in     (data_in),
        .data_out    (data_out),
        .sda         (sda),
        .scl         (scl),
        .sda_en      (sda_en),
        .busy        (busy),
        .done        (done),
        .nack        (nack)
    );

    always #5 clk_1MHz = ~clk_1MHz;

    int total = 0;
    int bad   = 0;

    // Frame plan produced by the model: one entry per SCL rising edge.
    logic item_slave [0:15];
    logic item_val   [0:15];
    int   n_items    = 0;
    logic plan_start = 1'b0;
    logic held_m     = 1'b0;
    logic arm_req    = 1'b0;

    // Monitor / slave state (written only by the monitor process).
    logic arm_seen       = 1'b0;
    logic rise_q [$];
    int   n_start        = 0;
    int   n_stop         = 0;
    int   slave_cd       = 0;
    logic first_fall_imm = 1'b0;
    logic prev_scl       = 1'b1;
    logic prev_sda       = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic add_item(input logic by_slave, input logic val);
        item_slave[n_items] = by_slave;
        item_val[n_items]   = val;
        n_items++;
    endtask

    // Slave presents its level for the next SCL rise, or lets go of the line.
    task automatic slave_update();
        int k;
        k = rise_q.size();
        if (k < n_items && item_slave[k]) begin
            slave_oe  = 1'b1;
            slave_bit = item_val[k];
        end else begin
            slave_oe = 1'b0;
        end
    endtask

    // Bus monitor and slave: records SCL-rise levels, START/STOP conditions, and
    // changes the slave's level only while SCL is low.
    always @(negedge clk_1MHz) begin
        if (arm_req != arm_seen) begin
            arm_seen = arm_req;
            rise_q.delete();
            n_start        = 0;
            n_stop         = 0;
            slave_cd       = 0;
            slave_oe       = 1'b0;
            first_fall_imm = scl && !plan_start;
            if (!scl) slave_update();
        end
        if (rst) begin
            slave_oe = 1'b0;
            slave_cd = 0;
        end else begin
            if (!prev_scl && scl) rise_q.push_back(sda);
            if (prev_scl && scl && prev_sda && !sda) n_start++;
            if (prev_scl && scl && !prev_sda && sda) n_stop++;
            if (slave_cd > 0) begin
                slave_cd--;
                if (slave_cd == 0) slave_update();
            end
            if (prev_scl && !scl) begin
                slave_oe = 1'b0;
                if (first_fall_imm) begin
                    first_fall_imm = 1'b0;
                    slave_update();
                end else begin
                    slave_cd = Q;
                end
            end
        end
        prev_scl = scl;
        prev_sda = sda;
    end

    task automatic do_frame(input logic s, input logic p_req, input logic r, input logic rn,
                            input logic [7:0] wd, input logic [7:0] rd, input logic ackb,
                            input int hold);
        logic        exp_p;
        int          lat;
        int          cyc;
        logic [15:0] exp_v;
        logic [15:0] got_v;

        n_items    = 0;
        exp_v      = 16'h0000;
        plan_start = s;
        if (s && held_m) add_item(1'b0, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            if (r) add_item(1'b1, rd[i]);
            else   add_item(1'b0, wd[i]);
        end
        if (r) add_item(1'b0, rn);
        else   add_item(1'b1, ackb);
        exp_p = p_req | (AUTOSTOP & ~r & ackb);
        if (exp_p) add_item(1'b0, 1'b0);
        for (int i = 0; i < n_items; i++) exp_v[i] = item_val[i];
        lat = 1 + Q * (36 + 4 * int'(s) + 4 * int'(exp_p));

        @(negedge clk_1MHz);
        arm_req     = ~arm_req;
        start_frame = s;
        stop_frame  = p_req;
        rw          = r;
        rd_nack     = rn;
        data_in     = wd;
        en          = 1'b1;
        @(posedge clk_1MHz);
        #1;
        chk("busy_rise", {31'd0, busy}, 32'd1);
        // Inputs are latched; anything applied now must not affect the frame.
        start_frame = 1'($urandom_range(0, 1));
        stop_frame  = 1'($urandom_range(0, 1));
        rw          = 1'($urandom_range(0, 1));
        rd_nack     = 1'($urandom_range(0, 1));
        data_in     = 8'($urandom);

        cyc = 0;
        while (done !== 1'b1 && cyc < 500) begin
            @(posedge clk_1MHz);
            #1;
            cyc++;
        end
        chk("latency", cyc, lat);
        chk("busy_done", {31'd0, busy}, 32'd0);
        chk("scl_end", {31'd0, scl}, {31'd0, exp_p});
        chk("sda_en_end", {31'd0, sda_en}, 32'd0);
        chk("nack", {31'd0, nack}, {31'd0, (~r & ackb)});
        if (r) chk("data_out", {24'd0, data_out}, {24'd0, rd});
        got_v = 16'h0000;
        for (int i = 0; i < rise_q.size() && i < 16; i++) got_v[i] = rise_q[i];
        chk("rise_cnt", rise_q.size(), n_items);
        chk("rise_bits", {16'd0, got_v}, {16'd0, exp_v});
        chk("n_start", n_start, {31'd0, s});
        chk("n_stop", n_stop, {31'd0, exp_p});
        held_m = ~exp_p;

        if (hold > 0) begin
            repeat (hold) @(posedge clk_1MHz);
            #1;
            chk("done_hold", {30'd0, done, busy}, 32'd2);
        end
        @(negedge clk_1MHz);
        en = 1'b0;
        @(posedge clk_1MHz);
        #1;
        chk("done_clear", {31'd0, done}, 32'd0);
    endtask

    task automatic reset_mid_frame();
        int cyc;
        int target;
        n_items    = 0;
        plan_start = 1'b1;
        target     = held_m ? 6 : 5;
        @(negedge clk_1MHz);
        arm_req     = ~arm_req;
        start_frame = 1'b1;
        stop_frame  = 1'b1;
        rw          = 1'b0;
        data_in     = 8'h00;
        en          = 1'b1;
        cyc = 0;
        while (rise_q.size() < target && cyc < 300) begin
            @(posedge clk_1MHz);
            #1;
            cyc++;
        end
        chk("rst_reach", {31'd0, (rise_q.size() >= target)}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid", {28'd0, scl, sda_en, busy, done}, 32'h8);
        en = 1'b0;
        @(negedge clk_1MHz);
        rst    = 1'b0;
        held_m = 1'b0;
    endtask

    initial begin
        en          = 1'b0;
        start_frame = 1'b0;
        stop_frame  = 1'b0;
        rw          = 1'b0;
        rd_nack     = 1'b0;
        data_in     = 8'h00;
        repeat (3) @(negedge clk_1MHz);
        chk("reset_state", {20'd0, data_out, scl, sda_en, busy, done}, {20'd0, 8'h00, 4'h8});
        chk("reset_nack", {31'd0, nack}, 32'd0);
        rst = 1'b0;
        @(negedge clk_1MHz);

        do_frame(1'b1, 1'b0, 1'b0, 1'b0, 8'hD4, 8'h00, 1'b0, 0);
        do_frame(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h2C, 1'b0, 0);
        do_frame(1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h00, 1'b1, 0);
        do_frame(1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h00, 1'b0, 0);
        do_frame(1'b1, 1'b1, 1'b0, 1'b0, 8'h81, 8'h00, 1'b0, 8);

        for (int n = 0; n < 24; n++) begin
            do_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 3)));
        end

        reset_mid_frame();
        do_frame(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h96, 1'b0, 2);
        do_frame(1'b1, 1'b1, 1'b0, 1'b0, 8'h5A, 8'h00, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
